// File: rtl/wb_pkg.sv
// Shared types for the writeback buffer.
//   wb_state_t       : drain FSM states (idle, issue start pulse, wait for burst end)
//   LINE_OFFSET_BITS : byte-offset bits inside a 64-byte line; dropped from stored addresses
//   wb_entry_t       : one buffered line {valid, line address, line data}
package wb_pkg;

  localparam int LINE_OFFSET_BITS = 6;
  localparam int ADDR_W           = 64;
  localparam int LINE_W           = 512;
  localparam int LINE_ADDR_W      = ADDR_W - LINE_OFFSET_BITS;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ISSUE,
    WB_WAIT
  } wb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Refill-forwarding match for the writeback buffer.
// Compares a probe line address against every buffered entry and returns the
// data of the youngest valid match. Purely combinational.
// Ports:
//   probe_line_i : probe line address (byte offset already removed)
//   valid_i      : per-entry valid bits
//   line_i       : per-entry line addresses
//   data_i       : per-entry line data
//   head_i       : index of the oldest entry
//   hit_o        : some valid entry matches
//   data_o       : data of the youngest matching entry, 0 when no hit
module wb_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic [LINE_ADDR_W-1:0] probe_line_i,
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [LINE_ADDR_W-1:0] line_i [DEPTH],
  input  logic [LINE_W-1:0]      data_i [DEPTH],
  input  logic [PTR_WIDTH-1:0]   head_i,
  output logic                   hit_o,
  output logic [LINE_W-1:0]      data_o
);

  logic [PTR_WIDTH-1:0] idx;

  // Valid entries are contiguous from the head, so walking oldest to youngest
  // and letting later matches overwrite earlier ones selects the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_WIDTH'(i);
      if (valid_i[idx] && (line_i[idx] == probe_line_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: holds dirty 64-byte lines evicted by the data cache and
// drains them one at a time into store_data, so the cache never waits on bus
// arbitration or the write burst.
// Build option: define WB_FORWARD_EN to enable refill forwarding (lookup_*);
// without it lookup_hit/lookup_data are tied to 0 and no comparators exist.
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   evict_valid/addr/data, evict_ready : push side from the cache (addr[5:0] ignored)
//   wb_enable      : one-cycle start pulse to store_data
//   wb_addr/wb_data: head line, stable from the start pulse until its pop
//   wb_ready       : store_data ready; a pop happens on its rising edge
//   lookup_addr/hit/data : refill probe against pending lines
//   empty          : no pending lines
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int DEPTH          = 4,
  parameter int PTR_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      evict_valid,
  input  logic [BUS_DATA_WIDTH-1:0] evict_addr,
  input  logic [LINE_WIDTH-1:0]     evict_data,
  output logic                      evict_ready,
  output logic                      wb_enable,
  output logic [BUS_DATA_WIDTH-1:0] wb_addr,
  output logic [LINE_WIDTH-1:0]     wb_data,
  input  logic                      wb_ready,
  input  logic [BUS_DATA_WIDTH-1:0] lookup_addr,
  output logic                      lookup_hit,
  output logic [LINE_WIDTH-1:0]     lookup_data,
  output logic                      empty
);

  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  wb_entry_t            entries_q [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  wb_state_t            state_q;
  logic                 wb_enable_q;
  logic                 ready_q;
  logic                 push;
  logic                 pop;
  wb_entry_t            head_entry;

  assign evict_ready = (count_q != FULL_COUNT);
  assign empty       = (count_q == '0);
  assign push        = evict_valid && evict_ready;
  // store_data keeps ready high while idle after a store, so only a
  // low-to-high transition seen during WAIT marks the end of our burst.
  assign pop         = (state_q == WB_WAIT) && !ready_q && wb_ready;

  assign head_entry = entries_q[head_q];
  assign wb_enable  = wb_enable_q;
  // Gated by valid so the unreset data storage never leaks out after reset.
  assign wb_addr    = head_entry.valid ? {head_entry.line_addr, {LINE_OFFSET_BITS{1'b0}}} : '0;
  assign wb_data    = head_entry.valid ? head_entry.data : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_ONE;
    if (pop)  head_d = head_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Only the valid bits are reset; address/data are qualified by valid.
  // The push is applied after the pop so it wins if both ever hit one slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
    end else begin
      if (pop)  entries_q[head_q].valid <= 1'b0;
      if (push) entries_q[tail_q] <= '{valid:     1'b1,
                                       line_addr: evict_addr[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS],
                                       data:      evict_data};
    end
  end

  // Drain FSM: IDLE -> ISSUE (one-cycle start pulse) -> WAIT (ready rise) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      wb_enable_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q     <= wb_ready;
      wb_enable_q <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (!empty) begin
            state_q     <= WB_ISSUE;
            wb_enable_q <= 1'b1;
          end
        end
        WB_ISSUE: state_q <= WB_WAIT;
        WB_WAIT: begin
          if (pop) state_q <= WB_IDLE;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0]       ent_valid;
  logic [LINE_ADDR_W-1:0] ent_line [DEPTH];
  logic [LINE_W-1:0]      ent_data [DEPTH];
  logic                   unused_offsets;

  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries_q[i].valid;
      ent_line[i]  = entries_q[i].line_addr;
      ent_data[i]  = entries_q[i].data;
    end
  end

  wb_lookup #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_lookup (
    .probe_line_i (lookup_addr[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS]),
    .valid_i      (ent_valid),
    .line_i       (ent_line),
    .data_i       (ent_data),
    .head_i       (head_q),
    .hit_o        (lookup_hit),
    .data_o       (lookup_data)
  );

  assign unused_offsets = ^{evict_addr[LINE_OFFSET_BITS-1:0], lookup_addr[LINE_OFFSET_BITS-1:0]};
`else
  logic unused_offsets;

  assign lookup_hit     = 1'b0;
  assign lookup_data    = '0;
  assign unused_offsets = ^{evict_addr[LINE_OFFSET_BITS-1:0], lookup_addr};
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Testbench for writeback_buffer with a behavioural store_data model:
// ready drops the cycle after enable, rises 11 cycles later, then holds high.
// 'stretch' optionally keeps ready high for extra cycles after enable.
module tb_writeback_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         evict_valid;
  logic [63:0]  evict_addr;
  logic [511:0] evict_data;
  logic         evict_ready;
  logic         wb_enable;
  logic [63:0]  wb_addr;
  logic [511:0] wb_data;
  logic         wb_ready;
  logic [63:0]  lookup_addr;
  logic         lookup_hit;
  logic [511:0] lookup_data;
  logic         empty;

  int checks   = 0;
  int failures = 0;
  int stretch  = 0;

  logic sd_ready;
  int   sd_hi;
  int   sd_lo;

  typedef struct packed {
    logic [63:0]  addr;
    logic [511:0] data;
  } line_t;

  line_t sb[$];

  always #5 clk = ~clk;

  writeback_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .evict_valid (evict_valid),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .evict_ready (evict_ready),
    .wb_enable   (wb_enable),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .empty       (empty)
  );

  assign wb_ready = sd_ready;

  // store_data model
  always @(posedge clk) begin
    if (reset) begin
      sd_ready <= 1'b1;
      sd_hi    <= 0;
      sd_lo    <= 0;
    end else if (wb_enable) begin
      if (stretch > 0) sd_hi <= stretch;
      else begin
        sd_ready <= 1'b0;
        sd_lo    <= 11;
      end
    end else if (sd_hi > 0) begin
      if (sd_hi == 1) begin
        sd_ready <= 1'b0;
        sd_lo    <= 11;
      end
      sd_hi <= sd_hi - 1;
    end else if (sd_lo > 0) begin
      if (sd_lo == 1) sd_ready <= 1'b1;
      sd_lo <= sd_lo - 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_data(input logic [63:0] base);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = base + 64'(k);
    return d;
  endfunction

  task automatic drive_push(input logic [63:0] a, input logic [511:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    sb.push_back('{addr: a & ~64'h3f, data: d});
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    lookup_addr = '0;
    tick();
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL reset_evict_ready got=%b exp=1", evict_ready); end
    checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL reset_wb_enable got=%b exp=0", wb_enable); end
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_lookup_hit got=%b exp=0", lookup_hit); end
    checks++; if (wb_addr !== 64'h0) begin failures++; $display("FAIL reset_wb_addr got=%h exp=0", wb_addr); end
    checks++; if (wb_data !== 512'h0) begin failures++; $display("FAIL reset_wb_data got_lo=%h exp=0", wb_data[63:0]); end
    checks++; if (lookup_data !== 512'h0) begin failures++; $display("FAIL reset_lookup_data got_lo=%h exp=0", lookup_data[63:0]); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    line_t e;
    int    cyc;
    logic  stable;
    drive_push(64'h1040, mk_data(64'h1));
    tick();
    evict_valid = 1'b0;
    checks++; if (wb_enable !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL single_accept enable=%b empty=%b exp enable=0 empty=0", wb_enable, empty); end
    tick();
    checks++; if (wb_enable !== 1'b1) begin failures++; $display("FAIL single_issue got=%b exp=1", wb_enable); end
    e = sb.pop_front();
    checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL single_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
    tick();
    checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", wb_enable); end
    cyc    = 1;
    stable = 1'b1;
    while (!empty && cyc < 40) begin
      if (wb_addr !== 64'h1040 || wb_enable !== 1'b0) stable = 1'b0;
      tick();
      cyc++;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL single_stable got=%b exp=1", stable); end
    checks++; if (cyc != 13) begin failures++; $display("FAIL single_pop_cycle got=%0d exp=13", cyc); end
  endtask

  task automatic test_back_to_back();
    line_t e;
    int    cyc = 0;
    int    ne = 0;
    int    en_t[4];
    for (int i = 0; i < 4; i++) begin
      checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_before_push%0d got=%b exp=1", i, evict_ready); end
      drive_push(64'h4000 + 64'(i) * 64'h40 + 64'(i), mk_data(64'h100 * 64'(i + 1)));
      tick();
      cyc++;
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL b2b_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
        if (ne < 4) en_t[ne] = cyc;
        ne++;
      end
    end
    evict_valid = 1'b0;
    checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", evict_ready); end
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      tick();
      cyc++;
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL b2b_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
        if (ne < 4) en_t[ne] = cyc;
        ne++;
      end
    end
    checks++; if (ne != 4) begin failures++; $display("FAIL b2b_issue_count got=%0d exp=4", ne); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (en_t[i] - en_t[i-1] != 14) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=14", i, en_t[i] - en_t[i-1]); end
    end
    for (int c = 0; c < 40 && !empty; c++) tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_final_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_pop();
    line_t e;
    int    k;
    for (int i = 0; i < 4; i++) begin
      drive_push(64'h8000 + 64'(i) * 64'h40, mk_data(64'h800 + 64'h10 * 64'(i)));
      tick();
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL full_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
      end
    end
    checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%b exp=0", evict_ready); end
    drive_push(64'h9000, mk_data(64'h900));
    k = 0;
    while (evict_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checks++; if (k != 11) begin failures++; $display("FAIL full_slot_free_cycle got=%0d exp=11", k); end
    if (k >= 40) void'(sb.pop_back());
    tick();
    evict_valid = 1'b0;
    checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL full_refilled_ready got=%b exp=0", evict_ready); end
    if (wb_enable) begin
      e = sb.pop_front();
      checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL full_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
    end
    for (int c = 0; c < 300 && sb.size() > 0; c++) begin
      tick();
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL full_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL full_drain_left got=%0d exp=0", sb.size()); end
    for (int c = 0; c < 40 && !empty; c++) tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_final_empty got=%b exp=1", empty); end
  endtask

  task automatic test_ready_held();
    line_t e;
    int    cyc;
    stretch = 5;
    drive_push(64'h5000, mk_data(64'h500));
    tick();
    evict_valid = 1'b0;
    tick();
    checks++; if (wb_enable !== 1'b1) begin failures++; $display("FAIL held_issue got=%b exp=1", wb_enable); end
    e = sb.pop_front();
    checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL held_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
    cyc = 0;
    while (!empty && cyc < 60) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 18) begin failures++; $display("FAIL held_pop_cycle got=%0d exp=18", cyc); end
    stretch = 0;
  endtask

  task automatic test_forward();
    line_t        e;
    logic         fwd;
    logic [511:0] dx;
    logic [511:0] dy;
    logic [511:0] dz;
`ifdef WB_FORWARD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    dx = mk_data(64'hA00);
    dy = mk_data(64'hB00);
    dz = mk_data(64'hC00);
    drive_push(64'h2000, dx);
    tick();
    drive_push(64'h2000, dy);
    tick();
    evict_valid = 1'b0;
    if (wb_enable) begin
      e = sb.pop_front();
      checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL fwd_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
    end
    lookup_addr = 64'h2010;
    #1;
    checks++; if (lookup_hit !== fwd) begin failures++; $display("FAIL fwd_hit_dup got=%b exp=%b", lookup_hit, fwd); end
    checks++; if (lookup_data !== (fwd ? dy : 512'h0)) begin failures++; $display("FAIL fwd_youngest_data got_lo=%h exp_lo=%h", lookup_data[63:0], fwd ? dy[63:0] : 64'h0); end
    lookup_addr = 64'h3000;
    #1;
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss got=%b exp=0", lookup_hit); end
    drive_push(64'h3000, dz);
    #1;
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL fwd_same_cycle_push got=%b exp=0", lookup_hit); end
    tick();
    evict_valid = 1'b0;
    checks++; if (lookup_hit !== fwd || lookup_data !== (fwd ? dz : 512'h0)) begin failures++; $display("FAIL fwd_after_push hit=%b exp=%b data_lo=%h", lookup_hit, fwd, lookup_data[63:0]); end
    for (int c = 0; c < 300 && sb.size() > 0; c++) begin
      tick();
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL fwd_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
      end
    end
    for (int c = 0; c < 40 && !empty; c++) tick();
    lookup_addr = 64'h2000;
    #1;
    checks++; if (lookup_hit !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL fwd_drained hit=%b empty=%b exp hit=0 empty=1", lookup_hit, empty); end
    lookup_addr = '0;
  endtask

  task automatic test_reset_mid();
    line_t e;
    int    ne;
    for (int i = 0; i < 3; i++) begin
      drive_push(64'h7000 + 64'(i) * 64'h40, mk_data(64'h700 + 64'h10 * 64'(i)));
      tick();
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL rstmid_line addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
      end
    end
    evict_valid = 1'b0;
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL rstmid_pending got=%b exp=0", empty); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    checks++; if (empty !== 1'b1 || wb_enable !== 1'b0 || evict_ready !== 1'b1) begin failures++; $display("FAIL rstmid_cleared empty=%b enable=%b ready=%b exp 1 0 1", empty, wb_enable, evict_ready); end
    ne = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (wb_enable) ne++;
    end
    checks++; if (ne != 0) begin failures++; $display("FAIL rstmid_no_issue got=%0d exp=0", ne); end
    drive_push(64'h6000, mk_data(64'h600));
    tick();
    evict_valid = 1'b0;
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      tick();
      if (wb_enable) begin
        e = sb.pop_front();
        checks++; if (wb_addr !== e.addr || wb_data !== e.data) begin failures++; $display("FAIL rstmid_restart addr=%h exp=%h data_lo=%h exp=%h", wb_addr, e.addr, wb_data[63:0], e.data[63:0]); end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rstmid_restart_left got=%0d exp=0", sb.size()); end
    for (int c = 0; c < 40 && !empty; c++) tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_final_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_ready_held();
    test_forward();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
